// File: rtl/field_op_sched_pkg.sv
// Shared types and helpers for the field arithmetic operation scheduler.
// Also supplies the default operand width `F_NBITS when no field definition header set it.
`ifndef F_NBITS
`define F_NBITS 16
`endif

package field_op_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FIRE = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/field_op_fifo.sv
// Operand-pair FIFO: power-of-2 depth, synchronous push/pop, async active-low reset.
// Push while full and pop while empty are ignored.
module field_op_fifo
  import field_op_sched_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 32,
  localparam int CW    = fifo_cnt_w(DEPTH),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/field_op_sched.sv
// Queues operand pairs and issues them one at a time to an edge-started field arithmetic unit.
// Optional watchdog on the unit's completion strobe: define FIELD_OP_SCHED_WDOG_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
// valid, once raised, holds its data stable until that edge; ready may change freely.
module field_op_sched
  import field_op_sched_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int WDOG_CYC = 64
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [`F_NBITS-1:0] in_a,
  input  logic [`F_NBITS-1:0] in_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [`F_NBITS-1:0] out_c,
  output logic                ar_en,
  output logic [`F_NBITS-1:0] ar_a,
  output logic [`F_NBITS-1:0] ar_b,
  input  logic                ar_ready_pulse,
  input  logic [`F_NBITS-1:0] ar_c,
  output logic                busy,
  output logic                err,
  output logic [1:0]          dbg_state_o
);

  localparam int W  = `F_NBITS;
  localparam int CW = fifo_cnt_w(DEPTH);

  state_e         state_q, state_d;
  logic           out_valid_q, out_valid_d;
  logic [W-1:0]   out_c_q, out_c_d;
  logic [W-1:0]   ar_a_q, ar_a_d, ar_b_q, ar_b_d;
  logic [W-1:0]   head_a, head_b;
  logic [2*W-1:0] fifo_rdata;
  logic           fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           wdog_expired;

  assign in_ready  = (fifo_count < CW'(DEPTH));
  assign fifo_push = in_valid && !fifo_full;
  assign fifo_pop  = (state_q == ST_FIRE);

  field_op_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * W)
  ) u_fifo (
    .clk     (clk),
    .rstb    (rstb),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i ({in_a, in_b}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign {head_a, head_b} = fifo_rdata;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    ar_a_d      = ar_a_q;
    ar_b_d      = ar_b_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && (!out_valid_q || out_ready)) state_d = ST_FIRE;
      end
      ST_FIRE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (ar_ready_pulse) begin
          out_c_d     = ar_c;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end else if (wdog_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = fifo_empty ? ST_IDLE : ST_FIRE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Operands freeze on FIRE entry so the unit sees them stable for the whole op.
    if (state_d == ST_FIRE && state_q != ST_FIRE) begin
      ar_a_d = head_a;
      ar_b_d = head_b;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      ar_a_q      <= '0;
      ar_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      ar_a_q      <= ar_a_d;
      ar_b_q      <= ar_b_d;
    end
  end

`ifdef FIELD_OP_SCHED_WDOG_EN
  localparam int WDW = $clog2(WDOG_CYC + 1);
  logic [WDW-1:0] wdog_q;
  logic           err_q;

  // Expires on the last of WDOG_CYC consecutive WAIT cycles without a strobe.
  assign wdog_expired = (wdog_q == WDW'(WDOG_CYC - 1));

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == ST_WAIT && !ar_ready_pulse) begin
        wdog_q <= wdog_q + 1'b1;
        if (wdog_expired) err_q <= 1'b1;
      end else begin
        wdog_q <= '0;
      end
    end
  end

  assign err = err_q;
`else
  assign wdog_expired = 1'b0;
  // WDOG_CYC has no effect in this build.
  assign err = 1'b0 & (WDOG_CYC > 0);
`endif

  assign ar_en       = (state_q == ST_FIRE);
  assign ar_a        = (state_q == ST_IDLE || state_q == ST_FIRE) ? head_a : ar_a_q;
  assign ar_b        = (state_q == ST_IDLE || state_q == ST_FIRE) ? head_b : ar_b_q;
  assign out_valid   = out_valid_q;
  assign out_c       = out_c_q;
  assign busy        = !fifo_empty || (state_q != ST_IDLE) || out_valid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_field_op_sched.sv
// Bench for field_op_sched: adder unit model, input driver, scoreboard monitor, directed and random phases.
`ifndef F_NBITS
`define F_NBITS 16
`endif

module tb_field_op_sched;
  import field_op_sched_pkg::*;

  localparam int W     = `F_NBITS;
  localparam int DEPTH = 4;
  localparam int WDOG  = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rstb = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_c;
  logic         ar_en;
  logic [W-1:0] ar_a, ar_b;
  logic         ar_ready_pulse = 1'b0;
  logic [W-1:0] ar_c = '0;
  logic         busy, err;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  field_op_sched #(
    .DEPTH    (DEPTH),
    .WDOG_CYC (WDOG)
  ) dut (
    .clk            (clk),
    .rstb           (rstb),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_c          (out_c),
    .ar_en          (ar_en),
    .ar_a           (ar_a),
    .ar_b           (ar_b),
    .ar_ready_pulse (ar_ready_pulse),
    .ar_c           (ar_c),
    .busy           (busy),
    .err            (err),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int           n_checks = 0;
  int           n_err = 0;
  bit           rand_mode = 1'b0;
  bit           ready_fixed = 1'b0;
  bit           rand_lat = 1'b0;
  bit           mute = 1'b0;
  bit           spur_req = 1'b0;
  logic [W-1:0] spur_val = '0;
  int           n_starts = 0;
  bit           saw_full = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- arithmetic unit model (adder) ----------------
  bit           m_busy = 1'b0, m_drop = 1'b0, m_pend = 1'b0, en_prev = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;

  always @(negedge clk) begin
    ar_ready_pulse = 1'b0;
    if (!rstb) begin
      m_busy  = 1'b0;
      m_pend  = 1'b0;
      en_prev = 1'b0;
      spur_req = 1'b0;
    end else begin
      if (m_pend) begin
        chk("valid_after_pulse", out_valid, 1);
        chk("out_c_capture", out_c, m_res);
        m_pend = 1'b0;
      end
      if (en_prev) chk("ar_en_one_cycle", ar_en, 0);
      if (m_busy) begin
        chk("ar_a_hold", ar_a, m_a);
        chk("ar_b_hold", ar_b, m_b);
        if (m_cnt <= 1) begin
          m_busy = 1'b0;
          if (!m_drop) begin
            ar_ready_pulse = 1'b1;
            ar_c   = m_res;
            m_pend = 1'b1;
          end
        end else begin
          m_cnt--;
        end
      end
      if (ar_en && !en_prev) begin
        n_starts++;
        m_busy = 1'b1;
        m_drop = mute;
        m_a    = ar_a;
        m_b    = ar_b;
        m_res  = ar_a + ar_b;
        m_cnt  = rand_lat ? int'($urandom_range(1, 5)) : 3;
      end
      if (spur_req) begin
        ar_ready_pulse = 1'b1;
        ar_c     = spur_val;
        spur_req = 1'b0;
      end
      en_prev = ar_en;
    end
  end

  // ---------------- consumer ready driver ----------------
  always @(posedge clk) begin
    #1;
    out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : ready_fixed;
  end

  // ---------------- monitor ----------------
  bit           ov_prev = 1'b0, or_prev = 1'b0;
  logic [W-1:0] oc_prev = '0;

  always @(negedge clk) begin
    if (rstb) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_result: got 0x%0h expected none at %0t", out_c, $time);
        end else begin
          chk("result_order", out_c, exp_q.pop_front());
        end
      end
      if (ov_prev && !or_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_out_c", out_c, oc_prev);
      end
      if (!in_ready) saw_full = 1'b1;
    end
    ov_prev = rstb && out_valid;
    or_prev = out_ready;
    oc_prev = out_c;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_res);
    int           t;
    bit           ok;
    logic [W-1:0] sum;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    t  = 0;
    ok = 1'b0;
    while (!ok && t < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else begin
        t++;
        @(posedge clk);
        #1;
      end
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: in_ready stuck 0 for %0d cycles, required 1", t);
    end else if (expect_res) begin
      sum = a + b;
      exp_q.push_back(sum);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle_timeout: pending=%0d busy=%0b, required 0/0", exp_q.size(), busy);
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] st, input string name);
    int t = 0;
    while (dbg_state !== st && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: state 0x%0h, required 0x%0h", name, dbg_state, st);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int           s0, wc, t;
    logic [W-1:0] oc;

    // Reset state
    #1 rstb = 1'b0;
    #2;
    chk("rst_ar_en", ar_en, 0);
    chk("rst_ar_a", ar_a, 0);
    chk("rst_ar_b", ar_b, 0);
    chk("rst_out_c", out_c, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rstb = 1'b1;
    cyc(2);
    chk("post_rst_no_start", n_starts, 0);

    // Isolated op 5+7
    ready_fixed = 1'b1;
    cyc(1);
    s0 = n_starts;
    send(W'(5), W'(7), 1'b1);
    cyc(1);
    chk("iso_fire_latency", ar_en, 1);
    wait_idle();
    chk("iso_starts", n_starts - s0, 1);
    chk("iso_out_c", out_c, 12);

    // Six back-to-back ops, FIFO fills
    saw_full = 1'b0;
    s0 = n_starts;
    for (int i = 0; i < 6; i++) send(W'(10 + i), W'(200 + 3 * i), 1'b1);
    wait_idle();
    chk("b2b_saw_full", saw_full, 1);
    chk("b2b_starts", n_starts - s0, 6);

    // Consumer stalls 20 cycles with 3 ops queued
    ready_fixed = 1'b0;
    cyc(1);
    s0 = n_starts;
    send(W'(1000), W'(1), 1'b1);
    send(W'(2000), W'(2), 1'b1);
    send(W'(3000), W'(3), 1'b1);
    cyc(20);
    chk("bp_one_start", n_starts - s0, 1);
    chk("bp_valid", out_valid, 1);
    chk("bp_state", dbg_state, ST_HOLD);
    ready_fixed = 1'b1;
    wait_idle();
    chk("bp_starts_total", n_starts - s0, 3);

    // Spurious strobe in IDLE
    cyc(2);
    oc = out_c;
    spur_val = ~oc;
    spur_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("spur_idle_state", dbg_state, ST_IDLE);
    chk("spur_idle_valid", out_valid, 0);
    chk("spur_idle_out_c", out_c, oc);
    cyc(1);

    // Spurious strobe in HOLD
    ready_fixed = 1'b0;
    cyc(1);
    send(W'(100), W'(23), 1'b1);
    wait_state(ST_HOLD, "spur_hold_reach");
    cyc(1);
    oc = out_c;
    spur_val = ~oc;
    spur_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("spur_hold_state", dbg_state, ST_HOLD);
    chk("spur_hold_out_c", out_c, oc);
    chk("spur_hold_out_c_val", out_c, 123);
    ready_fixed = 1'b1;
    wait_idle();

    // Reset while in WAIT with two queued
    send(W'(1), W'(2), 1'b1);
    send(W'(3), W'(4), 1'b1);
    send(W'(5), W'(6), 1'b1);
    wait_state(ST_WAIT, "rst_wait_reach");
    #2;
    rstb = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_ar_en", ar_en, 0);
    chk("midrst_ar_a", ar_a, 0);
    chk("midrst_ar_b", ar_b, 0);
    chk("midrst_out_c", out_c, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_err", err, 0);
    chk("midrst_state", dbg_state, ST_IDLE);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b1;
    s0 = n_starts;
    cyc(20);
    chk("midrst_no_start", n_starts - s0, 0);
    chk("midrst_idle_busy", busy, 0);

    // Randomized traffic
    rand_mode = 1'b1;
    rand_lat  = 1'b1;
    s0 = n_starts;
    for (int i = 0; i < 40; i++) begin
      send(W'($urandom), W'($urandom), 1'b1);
      cyc($urandom_range(0, 2));
    end
    rand_mode   = 1'b0;
    ready_fixed = 1'b1;
    wait_idle();
    rand_lat = 1'b0;
    chk("rand_starts", n_starts - s0, 40);

`ifdef FIELD_OP_SCHED_WDOG_EN
    // Unit never answers: watchdog drops op, next op proceeds
    chk("wdog_err_clear", err, 0);
    mute = 1'b1;
    s0 = n_starts;
    send(W'(9), W'(9), 1'b0);
    send(W'(11), W'(22), 1'b1);
    wc = 0;
    t  = 0;
    while (!err && t < 100) begin
      @(negedge clk);
      t++;
      if (!err && dbg_state == ST_WAIT) begin
        wc++;
        mute = 1'b0;
      end
    end
    mute = 1'b0;
    chk("wdog_err_set", err, 1);
    chk("wdog_wait_cycles", wc, WDOG);
    cyc(1);
    wait_idle();
    chk("wdog_err_sticky", err, 1);
    chk("wdog_starts", n_starts - s0, 2);
`else
    chk("err_tied_low", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
